// File: rtl/hdc_cls_pkg.sv
// rtl/hdc_cls_pkg.sv - shared FSM state type, class/frame constants and counter widths
package hdc_cls_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } seq_state_t;

    localparam int N_CLASSES = 8;
    localparam int N_FRAMES  = 3;
    localparam int CLS_W     = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
    localparam int FRM_W     = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;

endpackage

// File: rtl/class_hvec_gen.sv
// rtl/class_hvec_gen.sv - combinational class-vector frame generator addressed by (class, frame)
module class_hvec_gen
    import hdc_cls_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [CLS_W-1:0] cls,
    input  logic [FRM_W-1:0] frm,
    output logic [W-1:0]     data
);

    // Byte b of the frame is {class, frame, b}: every byte lane is distinct per beat.
    always_comb begin
        data = '0;
        for (int b = 0; b < W / 8; b++) begin
            data[b*8 +: 8] = 8'({cls, frm, 3'(b)});
        end
    end

endmodule

// File: rtl/class_hvec_seq.sv
// rtl/class_hvec_seq.sv - class-vector frame streamer; optional CLASS_HVEC_SEQ_SINGLE_CLASS_EN adds single-class passes
module class_hvec_seq #(
    parameter int DI_PARALLEL_W_BITS = 64,
    parameter int N_CLASSES          = hdc_cls_pkg::N_CLASSES,
    parameter int N_FRAMES           = hdc_cls_pkg::N_FRAMES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DI_PARALLEL_W_BITS-1:0] out_data,
    output logic [2:0]                    out_class,
    output logic [1:0]                    out_frame,
    output logic                          out_last
`ifdef CLASS_HVEC_SEQ_SINGLE_CLASS_EN
    ,
    input  logic [2:0]                    class_sel,
    input  logic                          single_mode
`endif
);
    import hdc_cls_pkg::*;

    localparam logic [CLS_W-1:0] CLS_MAX = CLS_W'(N_CLASSES - 1);
    localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(N_FRAMES - 1);

    seq_state_t                    state_q;
    seq_state_t                    state_d;
    logic [CLS_W-1:0]              cls_cnt;
    logic [FRM_W-1:0]              frm_cnt;
    logic                          single_q;
    logic                          cls_ok;
    logic                          start_single;
    logic [CLS_W-1:0]              start_cls;
    logic                          start_ok;
    logic                          load;
    logic                          beat_last;
    logic [DI_PARALLEL_W_BITS-1:0] gen_data;

`ifdef CLASS_HVEC_SEQ_SINGLE_CLASS_EN
    assign cls_ok       = int'(class_sel) < N_CLASSES;
    assign start_single = single_mode;
    assign start_cls    = single_mode ? CLS_W'(class_sel) : '0;
`else
    assign cls_ok       = 1'b1;
    assign start_single = 1'b0;
    assign start_cls    = '0;
`endif

    // done is high only in the cycle after a pass ends; a start there is refused.
    assign start_ok  = start && !abort && !done && cls_ok;
    assign load      = (state_q == STREAM) && (!out_valid || out_ready);
    assign beat_last = (frm_cnt == FRM_MAX) && (single_q || (cls_cnt == CLS_MAX));
    assign busy      = (state_q != IDLE);

    class_hvec_gen #(
        .W(DI_PARALLEL_W_BITS)
    ) u_gen (
        .cls (cls_cnt),
        .frm (frm_cnt),
        .data(gen_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) state_d = STREAM;
            end
            STREAM: begin
                if (abort) state_d = IDLE;
                else if (load && beat_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (abort) state_d = IDLE;
                else if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_cnt   <= '0;
            frm_cnt   <= '0;
            single_q  <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_class <= '0;
            out_frame <= '0;
            out_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state_q != IDLE)) begin
                out_valid <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_ok) begin
                            cls_cnt  <= start_cls;
                            frm_cnt  <= '0;
                            single_q <= start_single;
                        end
                    end
                    STREAM: begin
                        if (load) begin
                            out_valid <= 1'b1;
                            out_data  <= gen_data;
                            out_class <= 3'(cls_cnt);
                            out_frame <= 2'(frm_cnt);
                            out_last  <= beat_last;
                            if (frm_cnt == FRM_MAX) begin
                                frm_cnt <= '0;
                                cls_cnt <= cls_cnt + 1'b1;
                            end else begin
                                frm_cnt <= frm_cnt + 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                    default: out_valid <= 1'b0;
                endcase
            end
        end
    end

endmodule
